// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digitT;
endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth digit recoder: {y[2i+1], y[2i], y[2i-1]} -> digit in {-2..+2}.
module booth_recoder
  import booth_pkg::*;
(
  input  logic [2:0] bits,
  output digitT      digit
);
  always_comb begin
    digit = ZERO;
    case (bits)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end
endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one bit-pair per cycle, WIDTH/2+1 iterations.
// Define BOOTH_UNSIGNED_EN to add the is_signed port (0 = zero-extended operands).
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_product_high,
  output logic [WIDTH-1:0] out_product_low
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  stateT         state, nextState;
  logic [CW-1:0] cnt;
  logic [EW-1:0] xReg, yReg;
  logic [AW-1:0] acc, accNext, mult, shifted, addend;
  logic [2:0]    pairBits;
  logic          cin, signedMode, accept;
  digitT         digit;

`ifdef BOOTH_UNSIGNED_EN
  assign signedMode = is_signed;
`else
  assign signedMode = 1'b1;
`endif

  assign accept = start && (state != RUN);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = start ? RUN : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Window {y[2i+1], y[2i], y[2i-1]} with the implicit y[-1]=0 appended below bit 0.
  assign pairBits = 3'({yReg, 1'b0} >> {cnt, 1'b0});

  booth_recoder uRecoder (.bits(pairBits), .digit(digit));

  always_comb begin
    mult = '0;
    case (digit)
      POS1, NEG1: mult = {{(AW-EW){xReg[EW-1]}}, xReg};
      POS2, NEG2: mult = {{(AW-EW){xReg[EW-1]}}, xReg} << 1;
      default:    mult = '0;
    endcase
    shifted = mult << {cnt, 1'b0};
    // Negative digits: two's complement via inversion here and carry-in on the adder.
    cin     = (digit == NEG1) || (digit == NEG2);
    addend  = cin ? ~shifted : shifted;
    accNext = acc + addend + AW'(cin);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      xReg             <= '0;
      yReg             <= '0;
      acc              <= '0;
      cnt              <= '0;
      out_product_high <= '0;
      out_product_low  <= '0;
    end else if (accept) begin
      xReg <= signedMode ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
      yReg <= signedMode ? {{2{in_y[WIDTH-1]}}, in_y} : {2'b00, in_y};
      acc  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc <= accNext;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        out_product_high <= accNext[2*WIDTH-1:WIDTH];
        out_product_low  <= accNext[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench: directed table, random ops vs arithmetic model, multi-cycle corner sequences.
module tb_booth_seq_multiplier;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vecT;

  logic        clock = 1'b0;
  logic        clear, start, isSigned;
  logic [31:0] inX, inY;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          nVec = 0;
  int          nErr = 0;
  vecT         vecs[$];

  always #5 clock = ~clock;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(isSigned),
`endif
    .in_x(inX),
    .in_y(inY),
    .busy(busy),
    .done(done),
    .out_product_high(hi),
    .out_product_low(lo)
  );

  function automatic logic [63:0] refProd(logic [31:0] x, logic [31:0] y, logic sgn);
    longint      a, b;
    logic [63:0] ua, ub;
`ifndef BOOTH_UNSIGNED_EN
    sgn = 1'b1;
`endif
    if (sgn) begin
      a = longint'($signed(x));
      b = longint'($signed(y));
      return 64'(a * b);
    end
    ua = {32'b0, x};
    ub = {32'b0, y};
    return ua * ub;
  endfunction

  function automatic vecT mk(logic [31:0] x, logic [31:0] y, logic sgn,
                             logic [31:0] h, logic [31:0] l);
    vecT v;
    v.x = x; v.y = y; v.sgn = sgn; v.hi = h; v.lo = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after a bound).
  task automatic runOp(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                       output int lat);
    inX = x; inY = y; isSigned = sgn; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          lat, c, sawDone;
    logic [63:0] prev, exp;
    logic [31:0] rx, ry;
    logic        rs;

    vecs.push_back(mk(32'd7,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001));
    vecs.push_back(mk(32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE));
`ifdef BOOTH_UNSIGNED_EN
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE));
`endif

    // Reset with start held: start must be ignored while clear is high.
    clear = 1'b1; start = 1'b1; isSigned = 1'b1; inX = 32'd5; inY = 32'd5;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {hi, lo}, 64'd0);
    clear = 1'b0; start = 1'b0;
    @(negedge clock);
    check("start_during_clear_ignored", 64'(busy), 64'd0);

    foreach (vecs[i]) begin
      runOp(vecs[i].x, vecs[i].y, vecs[i].sgn, lat);
      check($sformatf("vec%0d_prod", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
      @(negedge clock);
      check($sformatf("vec%0d_done_pulse", i), 64'({busy, done}), 64'd0);
    end

    for (int k = 0; k < 30; k++) begin
      rx = $urandom;
      ry = $urandom;
      if (k % 5 == 0) rx = 32'h80000000;
      if (k % 7 == 3) ry = 32'hFFFFFFFF;
`ifdef BOOTH_UNSIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b1;
`endif
      runOp(rx, ry, rs, lat);
      check($sformatf("rand%0d_prod", k), {hi, lo}, refProd(rx, ry, rs));
      @(negedge clock);
    end

    // Start re-pulsed on RUN cycle 5 must be ignored.
    prev = {hi, lo};
    inX = 32'd1234; inY = 32'hFFFFFFB3; isSigned = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0; c = 1;
    while (c < 5) begin @(negedge clock); c++; end
    start = 1'b1; inX = 32'd9; inY = 32'd9;
    @(negedge clock);
    c++;
    start = 1'b0;
    check("repulse_busy", 64'(busy), 64'd1);
    check("repulse_hold_prod", {hi, lo}, prev);
    while (!done && c < 40) begin @(negedge clock); c++; end
    check("repulse_latency", 64'(c), 64'd18);
    check("repulse_prod", {hi, lo}, refProd(32'd1234, 32'hFFFFFFB3, 1'b1));
    @(negedge clock);
    check("repulse_no_second_op", 64'(busy), 64'd0);

    // Clear on RUN cycle 9 aborts with no done pulse.
    inX = 32'h1111; inY = 32'h2222; isSigned = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0; c = 1;
    while (c < 9) begin @(negedge clock); c++; end
    clear = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", {hi, lo}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    sawDone = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) sawDone++;
    end
    check("abort_no_done", 64'(sawDone), 64'd0);
    runOp(32'h00001111, 32'h00002222, 1'b1, lat);
    check("after_abort_latency", 64'(lat), 64'd18);
    check("after_abort_prod", {hi, lo}, 64'h0000000002468642);
    @(negedge clock);

    // Start held across DONE: back-to-back with no idle gap.
    inX = 32'hFFFF0001; inY = 32'h00000123; isSigned = 1'b1; start = 1'b1;
    @(negedge clock);
    lat = 1;
    inX = 32'h00ABCDEF; inY = 32'hFFFFFF00;
    while (!done && lat < 40) begin @(negedge clock); lat++; end
    check("b2b_first_latency", 64'(lat), 64'd18);
    check("b2b_first_prod", {hi, lo}, refProd(32'hFFFF0001, 32'h00000123, 1'b1));
    @(negedge clock);
    check("b2b_no_gap_busy", 64'(busy), 64'd1);
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin @(negedge clock); lat++; end
    check("b2b_second_latency", 64'(lat), 64'd18);
    check("b2b_second_prod", {hi, lo}, refProd(32'h00ABCDEF, 32'hFFFFFF00, 1'b1));
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
